// File: rtl/instr_sequencer_if.sv
// Sequencer-facing bundle: instruction fetch handshake, decoder hookup, ALU flags and datapath control.
// master = sequencer (drives fetch request and control), slave = surrounding CPU/memory.
interface instr_sequencer_if #(
   parameter int CW_WIDTH     = 31,
   parameter int RETIRE_WIDTH = 32
);
   logic                    imem_req;
   logic                    imem_ack;
   logic [31:0]             imem_data;
   logic [31:0]             ir;
   logic [1:0]              state;
   logic [4:0]              status;
   logic                    dec_valid;
   logic [CW_WIDTH-1:0]     dec_control_word;
   logic [1:0]              dec_next_state;
   logic                    dec_flag_load;
   logic [3:0]              alu_flags;
   logic                    alu_zero;
   logic                    stall;
   logic [CW_WIDTH-1:0]     control_word;
   logic [RETIRE_WIDTH-1:0] retired;
   logic [1:0]              fault;

   modport master (
      output imem_req, ir, state, status, control_word, retired, fault,
      input  imem_ack, imem_data, dec_valid, dec_control_word, dec_next_state,
             dec_flag_load, alu_flags, alu_zero, stall
   );

   modport slave (
      input  imem_req, ir, state, status, control_word, retired, fault,
      output imem_ack, imem_data, dec_valid, dec_control_word, dec_next_state,
             dec_flag_load, alu_flags, alu_zero, stall
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: fetch >=1 cycle, one micro-step per unstalled EXEC cycle.
// stall freezes the micro-step; fetch waits up to FETCH_TIMEOUT cycles for imem_ack before faulting.
module instr_sequencer #(
   parameter int CW_WIDTH      = 31,
   parameter int FETCH_TIMEOUT = 15,
   parameter int RETIRE_WIDTH  = 32
) (
   input logic                clock,
   input logic                reset_n,
   instr_sequencer_if.master  bus
);

   localparam int TW = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(FETCH_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } seq_state_t;

   seq_state_t              r_fsm;
   seq_state_t              w_fsm_nxt;
   logic [TW-1:0]           r_tcnt;
   logic [31:0]             r_ir;
   logic [1:0]              r_ustate;
   logic [3:0]              r_flags;
   logic [RETIRE_WIDTH-1:0] r_retired;
   logic [1:0]              r_fault;

   logic                    w_req;
   logic [CW_WIDTH-1:0]     w_cw;
   logic                    w_ld_ir;
   logic                    w_timeout;
   logic                    w_illegal;
   logic                    w_advance;
   logic                    w_retire;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_fsm <= S_FETCH;
      else          r_fsm <= w_fsm_nxt;
   end

   // An ack on the last allowed fetch cycle is checked first so it beats the timeout.
   always_comb begin
      w_fsm_nxt = r_fsm;
      w_req     = 1'b0;
      w_cw      = '0;
      w_ld_ir   = 1'b0;
      w_timeout = 1'b0;
      w_illegal = 1'b0;
      w_advance = 1'b0;
      w_retire  = 1'b0;
      case (r_fsm)
         S_FETCH: begin
            w_req = 1'b1;
            if (bus.imem_ack) begin
               w_ld_ir   = 1'b1;
               w_fsm_nxt = S_EXEC;
            end else if (r_tcnt == TLAST) begin
               w_timeout = 1'b1;
               w_fsm_nxt = S_HALT;
            end
         end
         S_EXEC: begin
            if (!bus.dec_valid) begin
               w_illegal = 1'b1;
               w_fsm_nxt = S_HALT;
            end else begin
               w_cw = bus.dec_control_word;
               if (!bus.stall) begin
                  w_advance = 1'b1;
                  if (bus.dec_next_state == 2'b00) begin
                     w_retire  = 1'b1;
                     w_fsm_nxt = S_FETCH;
                  end
               end
            end
         end
         S_HALT:  w_fsm_nxt = S_HALT;
         default: w_fsm_nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_tcnt    <= '0;
         r_ir      <= '0;
         r_ustate  <= 2'b00;
         r_flags   <= 4'b0000;
         r_retired <= '0;
         r_fault   <= 2'b00;
      end else begin
         if (w_ld_ir || w_timeout) r_tcnt <= '0;
         else if (w_req)           r_tcnt <= r_tcnt + 1'b1;

         if (w_ld_ir) begin
            r_ir     <= bus.imem_data;
            r_ustate <= 2'b00;
         end else if (w_advance) begin
            r_ustate <= bus.dec_next_state;
         end

         if (w_advance && bus.dec_flag_load) r_flags <= bus.alu_flags;
         if (w_retire) r_retired <= r_retired + 1'b1;

         // First fault recorded is kept until reset.
         if (r_fault == 2'b00) begin
            if (w_timeout)      r_fault <= 2'b10;
            else if (w_illegal) r_fault <= 2'b01;
         end
      end
   end

   // Request is held low while reset is asserted even though the FSM already sits in FETCH.
   assign bus.imem_req     = w_req & reset_n;
   assign bus.control_word = w_cw;
   assign bus.ir           = r_ir;
   assign bus.state        = r_ustate;
   assign bus.status       = {r_flags, bus.alu_zero};
   assign bus.retired      = r_retired;
   assign bus.fault        = r_fault;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed + randomized bench for instr_sequencer with a transaction-level expectation model.
module tb_instr_sequencer;

   logic clock;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   logic [3:0]  m_flags;
   logic [31:0] m_retired;
   logic [31:0] m_ir;

   instr_sequencer_if #(.CW_WIDTH(31), .RETIRE_WIDTH(32)) bus ();

   instr_sequencer #(
      .CW_WIDTH(31), .FETCH_TIMEOUT(15), .RETIRE_WIDTH(32)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic clear_inputs();
      bus.imem_ack         = 1'b0;
      bus.imem_data        = '0;
      bus.dec_valid        = 1'b1;
      bus.dec_control_word = '0;
      bus.dec_next_state   = 2'b00;
      bus.dec_flag_load    = 1'b0;
      bus.alu_flags        = 4'b0000;
      bus.alu_zero         = 1'b0;
      bus.stall            = 1'b0;
   endtask

   // Leaves the bench mid-cycle right after release, i.e. inside the first fetch cycle.
   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      m_flags   = 4'b0000;
      m_retired = '0;
      m_ir      = '0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic do_fetch(input int delay, input logic [31:0] data);
      for (int i = 0; i < delay; i++) begin
         bus.imem_ack  = 1'b0;
         bus.imem_data = $urandom;
         #1;
         chk("fetch_req", 64'(bus.imem_req), 64'(1));
         chk("fetch_cw_nop", 64'(bus.control_word), 64'(0));
         tick();
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = data;
      #1;
      chk("ack_req", 64'(bus.imem_req), 64'(1));
      tick();
      bus.imem_ack = 1'b0;
      m_ir = data;
      chk("ir_latch", 64'(bus.ir), 64'(data));
      chk("exec_state0", 64'(bus.state), 64'(0));
      chk("exec_req_low", 64'(bus.imem_req), 64'(0));
   endtask

   // n micro-steps counting 0,1,..,n-1 then back to 0; optional stall on one step.
   task automatic do_exec(input int n, input int st_step, input int st_cyc,
                          input bit dir_flags, input bit use_cw, input logic [30:0] cw_f);
      logic [30:0] cw;
      logic        fl;
      logic [3:0]  af;
      logic        z;
      for (int k = 0; k < n; k++) begin
         cw = use_cw ? cw_f : 31'($urandom);
         bus.dec_valid        = 1'b1;
         bus.dec_control_word = cw;
         bus.dec_next_state   = (k == n - 1) ? 2'd0 : 2'(k + 1);
         if (k == st_step) begin
            for (int s = 0; s < st_cyc; s++) begin
               bus.stall         = 1'b1;
               bus.dec_flag_load = 1'b1;
               bus.alu_flags     = 4'($urandom);
               z                 = 1'($urandom);
               bus.alu_zero      = z;
               bus.imem_ack      = 1'($urandom);
               bus.imem_data     = $urandom;
               #1;
               chk("stall_cw", 64'(bus.control_word), 64'(cw));
               chk("stall_state", 64'(bus.state), 64'(k));
               chk("stall_zi", 64'(bus.status[0]), 64'(z));
               tick();
               chk("stall_flags", 64'(bus.status[4:1]), 64'(m_flags));
               chk("stall_retired", 64'(bus.retired), 64'(m_retired));
               chk("stall_ir", 64'(bus.ir), 64'(m_ir));
            end
         end
         fl = dir_flags ? 1'b1 : 1'($urandom);
         af = dir_flags ? 4'b0110 : 4'($urandom);
         bus.stall         = 1'b0;
         bus.dec_flag_load = fl;
         bus.alu_flags     = af;
         bus.imem_ack      = 1'($urandom);
         bus.imem_data     = $urandom;
         #1;
         chk("step_cw", 64'(bus.control_word), 64'(cw));
         chk("step_state", 64'(bus.state), 64'(k));
         chk("step_req_low", 64'(bus.imem_req), 64'(0));
         tick();
         if (fl) m_flags = af;
         chk("step_flags", 64'(bus.status[4:1]), 64'(m_flags));
         chk("step_ir_hold", 64'(bus.ir), 64'(m_ir));
      end
      bus.imem_ack      = 1'b0;
      bus.dec_flag_load = 1'b0;
      m_retired++;
      #1;
      chk("retired", 64'(bus.retired), 64'(m_retired));
      chk("refetch_req", 64'(bus.imem_req), 64'(1));
      chk("refetch_state", 64'(bus.state), 64'(0));
      chk("refetch_cw_nop", 64'(bus.control_word), 64'(0));
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      m_flags = 4'b0000; m_retired = '0; m_ir = '0;
      #1;
      bus.dec_control_word = 31'h7FFF_FFFF;
      #1;
      chk("rst_cw", 64'(bus.control_word), 64'(0));
      chk("rst_req", 64'(bus.imem_req), 64'(0));
      chk("rst_ir", 64'(bus.ir), 64'(0));
      chk("rst_state", 64'(bus.state), 64'(0));
      chk("rst_flags", 64'(bus.status[4:1]), 64'(0));
      chk("rst_retired", 64'(bus.retired), 64'(0));
      chk("rst_fault", 64'(bus.fault), 64'(0));
      repeat (2) @(posedge clock);
      do_reset();
      #1;
      chk("post_rst_req", 64'(bus.imem_req), 64'(1));

      // CBZ: ack after 3 wait cycles, single-step decode with Psel=11
      do_fetch(3, 32'hB400_0041);
      do_exec(1, 9, 0, 1'b0, 1'b1, {2'b11, 29'($urandom)});

      // three-step decode with a 2-cycle stall on the second step
      do_fetch($urandom_range(0, 4), $urandom);
      do_exec(3, 1, 2, 1'b0, 1'b0, '0);

      // flag load 0110, blocked while stalled
      do_fetch(0, $urandom);
      do_exec(1, 0, 1, 1'b1, 1'b0, '0);

      for (int t = 0; t < 30; t++) begin
         do_fetch($urandom_range(0, 6), $urandom);
         do_exec($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 2),
                 1'b0, 1'b0, '0);
      end

      // reset while in micro-state 01 with flags 1010
      do_fetch(0, $urandom);
      bus.dec_control_word = 31'($urandom) | 31'h1;
      bus.dec_next_state   = 2'b01;
      bus.dec_flag_load    = 1'b1;
      bus.alu_flags        = 4'b1010;
      tick();
      chk("pre_rst_state", 64'(bus.state), 64'(1));
      chk("pre_rst_flags", 64'(bus.status[4:1]), 64'(4'b1010));
      reset_n = 1'b0;
      #1;
      chk("mid_rst_cw", 64'(bus.control_word), 64'(0));
      chk("mid_rst_flags", 64'(bus.status[4:1]), 64'(0));
      chk("mid_rst_retired", 64'(bus.retired), 64'(0));
      chk("mid_rst_state", 64'(bus.state), 64'(0));
      chk("mid_rst_req", 64'(bus.imem_req), 64'(0));
      do_reset();
      #1;
      chk("mid_rst_release_req", 64'(bus.imem_req), 64'(1));

      // ack exactly on the 15th fetch cycle is accepted
      do_fetch(14, $urandom);
      chk("late_ack_fault", 64'(bus.fault), 64'(0));
      do_exec(2, 0, 1, 1'b0, 1'b0, '0);

      // illegal opcode
      do_fetch(1, $urandom);
      bus.dec_valid        = 1'b0;
      bus.dec_control_word = 31'($urandom) | 31'h1;
      #1;
      chk("illegal_cw", 64'(bus.control_word), 64'(0));
      tick();
      bus.dec_valid = 1'b1;
      #1;
      chk("illegal_fault", 64'(bus.fault), 64'(2'b01));
      chk("illegal_retired", 64'(bus.retired), 64'(m_retired));
      chk("illegal_halt_req", 64'(bus.imem_req), 64'(0));
      chk("illegal_halt_cw", 64'(bus.control_word), 64'(0));

      // fetch timeout
      do_reset();
      for (int i = 0; i < 15; i++) begin
         #1;
         chk("to_wait_req", 64'(bus.imem_req), 64'(1));
         chk("to_wait_fault", 64'(bus.fault), 64'(0));
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         bus.imem_ack         = 1'b1;
         bus.imem_data        = $urandom;
         bus.dec_valid        = 1'b1;
         bus.dec_control_word = 31'($urandom) | 31'h1;
         #1;
         chk("to_fault", 64'(bus.fault), 64'(2'b10));
         chk("to_req", 64'(bus.imem_req), 64'(0));
         chk("to_cw", 64'(bus.control_word), 64'(0));
         chk("to_retired", 64'(bus.retired), 64'(0));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
